fetch: RTL

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset defaults, the
// FSM state encoding and the {pc, instr} buffer entry.
package fetch_pkg;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between the imem response and decode.
// Flush wins over push/pop; push and pop together on a full buffer is lossless.
module fetch_fifo import fetch_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  entry_t     wdata,
  output entry_t     rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  entry_t     mem [2];
  logic       wptr, rptr;
  logic       do_push, do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request at a time, responses
// buffered in a 2-entry FIFO toward decode, redirect flushes and refetches.
module fetch import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);
  state_t      state, state_nx;
  logic [31:0] fpc, ipc, last_pc;
  logic        push, pop, full, empty;
  logic [1:0]  count;
  logic [2:0]  cnt_after;
  entry_t      wdata, head;

  assign imem_req_o  = (state == S_REQ);
  assign imem_addr_o = fpc;

  // Redirect suppresses both sides of the buffer; the flush does the rest.
  assign push      = (state == S_WAIT) & imem_rvalid_i & ~redirect_i;
  assign pop       = ~empty & instr_ready_i & ~redirect_i;
  assign cnt_after = {1'b0, count} + {2'b0, push} - {2'b0, pop};
  assign wdata     = '{pc: ipc, instr: imem_rdata_i};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!redirect_i && !full) state_nx = S_REQ;
      S_REQ:     if (imem_gnt_i)      state_nx = redirect_i ? S_DISCARD : S_WAIT;
                 else if (redirect_i) state_nx = S_IDLE;
      S_WAIT:    if (redirect_i)         state_nx = imem_rvalid_i ? S_IDLE : S_DISCARD;
                 else if (imem_rvalid_i) state_nx = (cnt_after < 3'd2) ? S_REQ : S_IDLE;
      S_DISCARD: if (imem_rvalid_i) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      fpc     <= RESET_PC;
      ipc     <= RESET_PC;
      last_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect_i)
        fpc <= redirect_pc_i & ~32'h3;
      else if (imem_req_o && imem_gnt_i)
        fpc <= fpc + 32'd4;
      if (imem_req_o && imem_gnt_i) ipc <= fpc;
      // pc_o keeps showing the last presented address once the buffer drains.
      if (!empty) last_pc <= head.pc;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign instr_valid_o = ~empty;
  assign instr_o       = empty ? NOP_INSTR : head.instr;
  assign pc_o          = empty ? last_pc   : head.pc;
endmodule
